// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle MIPS main control FSM.
// State numbering is visible on the debug state output, so the values are fixed.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        StIf     = 4'd0,
        StId     = 4'd1,
        StExR    = 4'd2,
        StWbR    = 4'd3,
        StAddr   = 4'd4,
        StMemRd  = 4'd5,
        StWbLw   = 4'd6,
        StMemWr  = 4'd7,
        StBeq    = 4'd8,
        StJ      = 4'd9,
        StExAddi = 4'd10,
        StWbAddi = 4'd11
    } state_e;

    localparam logic [5:0] OpR    = 6'b000000;
    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpJ    = 6'b000010;
    localparam logic [5:0] OpAddi = 6'b001000;

    // ALU class handed to alu_controller
    localparam logic [1:0] AluMtype = 2'b00;
    localparam logic [1:0] AluBtype = 2'b01;
    localparam logic [1:0] AluRtype = 2'b10;
    localparam logic [1:0] AluJtype = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    localparam logic [1:0] SrcBReg    = 2'b00;
    localparam logic [1:0] SrcBFour   = 2'b01;
    localparam logic [1:0] SrcBImm    = 2'b10;
    localparam logic [1:0] SrcBImmSh2 = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_ctrl;
        logic       instr_done;
        logic       illegal_op;
        logic       mem_err;
    } ctrl_t;

    // States that wait on mem_ready and are guarded by the timeout counter
    function automatic logic is_wait_state(input state_e st);
        return (st == StIf) || (st == StMemRd) || (st == StMemWr);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory signal bundle. The controller takes the master side;
// the datapath (or a testbench) takes the slave side.
interface multicycle_controller_if;

    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_ctrl;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_err;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctrl,
               instr_done, illegal_op, mem_err, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctrl,
               instr_done, illegal_op, mem_err, state
    );

endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS datapath: sequences IF/ID/EX/MEM/WB, drives the
// datapath enables and the ALU class, and aborts memory waits that exceed MEM_TIMEOUT cycles.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_controller_if.master bus
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl, ctrl_out;
    logic             wait_st, timeout;
    logic             unused_zero;

    // The zero flag is consumed by the datapath's PC-write gating, not by the FSM
    assign unused_zero = bus.zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIf;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        wait_st = is_wait_state(state_q);
        timeout = wait_st && !bus.mem_ready && (cnt_q >= CntLast);
        cnt_d   = '0;
        // Counting only while stalled; any transition (or timeout re-entry) restarts at zero
        if (wait_st && !bus.mem_ready && !timeout) begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_comb begin
        ctrl    = '0;
        state_d = state_q;

        unique case (state_q)
            StIf: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SrcBFour;
                ctrl.alu_ctrl  = AluMtype;
                ctrl.ir_write  = bus.mem_ready;
                ctrl.pc_write  = bus.mem_ready;
                if (bus.mem_ready) state_d = StId;
            end
            StId: begin
                ctrl.alu_src_b = SrcBImmSh2;
                ctrl.alu_ctrl  = AluMtype;
                unique case (bus.opcode)
                    OpR:        state_d = StExR;
                    OpLw, OpSw: state_d = StAddr;
                    OpBeq:      state_d = StBeq;
                    OpJ:        state_d = StJ;
                    OpAddi:     state_d = StExAddi;
                    default: begin
                        ctrl.illegal_op = 1'b1;
                        state_d         = StIf;
                    end
                endcase
            end
            StExR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBReg;
                ctrl.alu_ctrl  = AluRtype;
                state_d        = StWbR;
            end
            StWbR: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = StIf;
            end
            StAddr: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBImm;
                ctrl.alu_ctrl  = AluMtype;
                state_d        = (bus.opcode == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                if (bus.mem_ready) state_d = StWbLw;
            end
            StWbLw: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = StIf;
            end
            StMemWr: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                if (bus.mem_ready) begin
                    ctrl.instr_done = 1'b1;
                    state_d         = StIf;
                end
            end
            StBeq: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SrcBReg;
                ctrl.alu_ctrl      = AluBtype;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PcSrcAluOut;
                ctrl.instr_done    = 1'b1;
                state_d            = StIf;
            end
            StJ: begin
                ctrl.alu_ctrl   = AluJtype;
                ctrl.pc_write   = 1'b1;
                ctrl.pc_src     = PcSrcJump;
                ctrl.instr_done = 1'b1;
                state_d         = StIf;
            end
            StExAddi: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBImm;
                ctrl.alu_ctrl  = AluMtype;
                state_d        = StWbAddi;
            end
            StWbAddi: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = StIf;
            end
            default: state_d = StIf;
        endcase

        // A timed-out access must not commit anything; fall back to a fresh fetch
        if (timeout) begin
            ctrl.pc_write      = 1'b0;
            ctrl.pc_write_cond = 1'b0;
            ctrl.ir_write      = 1'b0;
            ctrl.mem_write     = 1'b0;
            ctrl.reg_write     = 1'b0;
            ctrl.instr_done    = 1'b0;
            ctrl.mem_err       = 1'b1;
            state_d            = StIf;
        end
    end

    // IF decodes to active read/PC controls, so outputs are gated explicitly during reset
    assign ctrl_out = rst_n ? ctrl : '0;

    assign bus.pc_write      = ctrl_out.pc_write;
    assign bus.pc_write_cond = ctrl_out.pc_write_cond;
    assign bus.pc_src        = ctrl_out.pc_src;
    assign bus.i_or_d        = ctrl_out.i_or_d;
    assign bus.mem_read      = ctrl_out.mem_read;
    assign bus.mem_write     = ctrl_out.mem_write;
    assign bus.ir_write      = ctrl_out.ir_write;
    assign bus.reg_dst       = ctrl_out.reg_dst;
    assign bus.mem_to_reg    = ctrl_out.mem_to_reg;
    assign bus.reg_write     = ctrl_out.reg_write;
    assign bus.alu_src_a     = ctrl_out.alu_src_a;
    assign bus.alu_src_b     = ctrl_out.alu_src_b;
    assign bus.alu_ctrl      = ctrl_out.alu_ctrl;
    assign bus.instr_done    = ctrl_out.instr_done;
    assign bus.illegal_op    = ctrl_out.illegal_op;
    assign bus.mem_err       = ctrl_out.mem_err;
    assign bus.state         = rst_n ? state_q : StIf;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: each instruction is expanded into an expected per-cycle trace
// (state + every control output) from the instruction's timing rules, then replayed on the DUT.
module tb_multicycle_controller;

    localparam int TO = 4;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_ctrl;
        logic       instr_done;
        logic       illegal_op;
        logic       mem_err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    exp_t ex_q[$];
    logic rdy_q[$];

    multicycle_controller_if bus ();

    multicycle_controller #(
        .MEM_TIMEOUT(TO),
        .CNT_W      (5)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t actual();
        exp_t a;
        a = {bus.state, bus.pc_write, bus.pc_write_cond, bus.pc_src, bus.i_or_d, bus.mem_read,
             bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
             bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl, bus.instr_done, bus.illegal_op,
             bus.mem_err};
        return a;
    endfunction

    function automatic exp_t mk(input int st);
        exp_t e;
        e    = '0;
        e.st = 4'(st);
        return e;
    endfunction

    function automatic void push(input exp_t e, input logic r);
        ex_q.push_back(e);
        rdy_q.push_back(r);
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Fetch: waits of any length, every TO-th consecutive stalled cycle is a timeout
    function automatic void plan_fetch(input int if_wait);
        exp_t e;
        for (int k = 0; k < if_wait; k++) begin
            e = mk(0);
            e.mem_read  = 1'b1;
            e.alu_src_b = 2'b01;
            e.mem_err   = ((k % TO) == TO - 1);
            push(e, 1'b0);
        end
        e = mk(0);
        e.mem_read  = 1'b1;
        e.alu_src_b = 2'b01;
        e.ir_write  = 1'b1;
        e.pc_write  = 1'b1;
        push(e, 1'b1);
    endfunction

    function automatic void plan_decode(input logic [5:0] op);
        exp_t e;
        e = mk(1);
        e.alu_src_b  = 2'b11;
        e.illegal_op = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                                    6'b001000});
        push(e, rnd_bit());
    endfunction

    // Returns 1 when the access completes, 0 when it timed out
    function automatic logic plan_mem(input int st, input int mem_wait, input logic is_wr);
        exp_t e;
        for (int k = 0; k < mem_wait; k++) begin
            e = mk(st);
            e.i_or_d    = 1'b1;
            e.mem_read  = !is_wr;
            e.mem_write = is_wr;
            if (k == TO - 1) begin
                e.mem_err   = 1'b1;
                e.mem_write = 1'b0;
                push(e, 1'b0);
                return 1'b0;
            end
            push(e, 1'b0);
        end
        e = mk(st);
        e.i_or_d     = 1'b1;
        e.mem_read   = !is_wr;
        e.mem_write  = is_wr;
        e.instr_done = is_wr;
        push(e, 1'b1);
        return 1'b1;
    endfunction

    function automatic void plan_body(input logic [5:0] op, input int mem_wait);
        exp_t e;
        case (op)
            6'b000000: begin
                e = mk(2); e.alu_src_a = 1'b1; e.alu_ctrl = 2'b10; push(e, rnd_bit());
                e = mk(3); e.reg_dst = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1;
                push(e, rnd_bit());
            end
            6'b100011, 6'b101011: begin
                e = mk(4); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; push(e, rnd_bit());
                if (op == 6'b101011) begin
                    void'(plan_mem(7, mem_wait, 1'b1));
                end else if (plan_mem(5, mem_wait, 1'b0)) begin
                    e = mk(6); e.mem_to_reg = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1;
                    push(e, rnd_bit());
                end
            end
            6'b000100: begin
                e = mk(8); e.alu_src_a = 1'b1; e.alu_ctrl = 2'b01; e.pc_write_cond = 1'b1;
                e.pc_src = 2'b01; e.instr_done = 1'b1; push(e, rnd_bit());
            end
            6'b000010: begin
                e = mk(9); e.alu_ctrl = 2'b11; e.pc_write = 1'b1; e.pc_src = 2'b10;
                e.instr_done = 1'b1; push(e, rnd_bit());
            end
            6'b001000: begin
                e = mk(10); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; push(e, rnd_bit());
                e = mk(11); e.reg_write = 1'b1; e.instr_done = 1'b1; push(e, rnd_bit());
            end
            default: ;
        endcase
    endfunction

    // Replays the planned trace; caller is positioned between a negedge and the next posedge
    task automatic run_plan(input string tag, input logic zero_v, input logic zero_rand);
        exp_t e;
        exp_t a;
        while (ex_q.size() > 0) begin
            e = ex_q.pop_front();
            bus.mem_ready = rdy_q.pop_front();
            bus.zero      = zero_rand ? rnd_bit() : zero_v;
            #1;
            a = actual();
            n_cmp++;
            if (a.st !== e.st) begin
                n_bad++;
                $display("FAIL %s state: got %0d expected %0d", tag, a.st, e.st);
            end
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s outputs (st %0d): got %h expected %h", tag, e.st, a, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic run_instr(input string tag, input logic [5:0] op, input int if_wait,
                             input int mem_wait, input logic zero_v, input logic zero_rand);
        bus.opcode = op;
        plan_fetch(if_wait);
        plan_decode(op);
        plan_body(op, mem_wait);
        run_plan(tag, zero_v, zero_rand);
    endtask

    task automatic check_zero(input string tag);
        exp_t a;
        a = actual();
        n_cmp++;
        if (a !== '0) begin
            n_bad++;
            $display("FAIL %s: got %h expected 0", tag, a);
        end
    endtask

    task automatic test_reset();
        bus.mem_ready = 1'b1;
        bus.opcode    = 6'b000000;
        #1;
        check_zero("reset_ready_hi");
        bus.mem_ready = 1'b0;
        #1;
        check_zero("reset_ready_lo");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_r_add();
        run_instr("r_add", 6'b000000, 0, 0, 1'b0, 1'b1);
        run_instr("addi", 6'b001000, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_lw_wait();
        run_instr("lw_wait3", 6'b100011, 0, 3, 1'b0, 1'b1);
        run_instr("lw_nowait", 6'b100011, 1, 0, 1'b0, 1'b1);
    endtask

    task automatic test_beq();
        run_instr("beq_z1", 6'b000100, 0, 0, 1'b1, 1'b0);
        run_instr("beq_z0", 6'b000100, 0, 0, 1'b0, 1'b0);
        run_instr("jump", 6'b000010, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_illegal();
        run_instr("illegal", 6'b111111, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_timeout();
        run_instr("sw_timeout", 6'b101011, 0, 100, 1'b0, 1'b1);
        run_instr("sw_ok", 6'b101011, 0, 2, 1'b0, 1'b1);
        run_instr("lw_timeout", 6'b100011, 0, 100, 1'b0, 1'b1);
        run_instr("if_timeout", 6'b000000, 5, 0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        exp_t a;
        bus.opcode = 6'b000000;
        plan_fetch(0);
        plan_decode(6'b000000);
        run_plan("rmid_pre", 1'b0, 1'b1);
        bus.mem_ready = 1'b1;
        #1;
        e = mk(2); e.alu_src_a = 1'b1; e.alu_ctrl = 2'b10;
        a = actual();
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL rmid_exr: got %h expected %h", a, e);
        end
        rst_n = 1'b0;
        #1;
        check_zero("rmid_async");
        @(negedge clk);
        #1;
        check_zero("rmid_held");
        rst_n = 1'b1;
        run_instr("rmid_post", 6'b000000, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [5:0] ops[7];
        logic [5:0] op;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b110011};
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 6)];
            run_instr("random", op, $urandom_range(0, 5), $urandom_range(0, 5), 1'b0, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        run_instr("b2b_sw", 6'b101011, 0, 0, 1'b0, 1'b1);
        run_instr("b2b_lw", 6'b100011, 0, 0, 1'b0, 1'b1);
        run_instr("b2b_j", 6'b000010, 0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        rst_n         = 1'b0;
        bus.opcode    = '0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_r_add();
        test_lw_wait();
        test_beq();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
